dac_stream_ctrl: RTL and testbench
==================================

DAC_STREAM_CTRL -- requirements
Module: dac_stream_ctrl

Interface
REQ-001 Parameter DW, default 8, DAC sample width in bits.
REQ-002 Parameter DEPTH, default 16, sample FIFO depth; power of two, minimum 4.
REQ-003 Parameter DIV, default 4, clk cycles per DAC sample; even, minimum 2.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 en  in  1  playback enable; sampled every clk.
REQ-007 s_data  in  DW  input sample.
REQ-008 s_valid  in  1  s_data valid.
REQ-009 s_ready  out  1  FIFO can accept a sample.
REQ-010 clr_uf  in  1  clears the underflow flag.
REQ-011 da_data  out  DW  registered sample to the DAC pins.
REQ-012 clk_dac  out  1  registered DAC conversion clock; the DAC latches on its rising edge.
REQ-013 level  out  log2(DEPTH)+1  FIFO occupancy.
REQ-014 underflow  out  1  sticky flag: a sample tick found the FIFO empty.

Function
REQ-015 The FIFO SHALL push on every clk where s_valid and s_ready are both high; s_ready SHALL equal (level != DEPTH), driven combinationally from registered level.
REQ-016 FIFO pointers SHALL wrap modulo DEPTH; level SHALL count 0..DEPTH.
REQ-017 A push and a pop in the same clk SHALL leave level unchanged.
REQ-018 The sample counter SHALL count 0..DIV-1 while en=1; a sample tick SHALL occur when the count is DIV-1.
REQ-019 clk_dac SHALL be low for count 0..DIV/2-1 and high for count DIV/2..DIV-1, giving a 50% duty square wave of period DIV.
REQ-020 The FSM SHALL have three states: IDLE, PRIME and RUN.
REQ-021 IDLE: the counter is held at 0 and clk_dac is low. Transition to PRIME when en=1.
REQ-022 PRIME: the counter runs and no pop occurs. Transition to RUN on the first tick where level >= DEPTH/2.
REQ-023 RUN, tick with level != 0: pop one sample; da_data updates on the next clk, while clk_dac is low.
REQ-024 RUN, tick with level == 0: da_data holds its value, underflow sets, and the FSM goes to PRIME.
REQ-025 Any state with en=0: go to IDLE next clk; FIFO contents and da_data are retained.
REQ-026 Pop-to-da_data latency SHALL be 1 clk; da_data SHALL be stable for a full clk_dac high phase.
REQ-027 underflow SHALL clear on clr_uf=1. If a set event and clr_uf occur in the same clk, set wins.
REQ-028 A push into an empty FIFO in the same clk as a RUN tick SHALL count as an underflow; the pushed sample is stored.

Reset
REQ-029 rst=1 SHALL asynchronously force: state IDLE, counter 0, pointers 0, level 0, da_data 0, clk_dac 0, underflow 0.
REQ-030 s_ready SHALL be 1 after reset, because level=0 and DEPTH>0.
REQ-031 rst asserted mid-playback SHALL discard all FIFO contents; there is no partial-state recovery.

Configuration
REQ-032 Macro DAC_SIGNED_IN_EN defined: s_data is two's complement; the MSB is inverted at the FIFO output, giving offset binary, so da_data reset value 0 maps to code 0.
REQ-033 Macro DAC_SIGNED_IN_EN undefined: s_data is passed unmodified as offset binary.

Verification
REQ-034 Defaults, push 8 samples 0x10..0x17, then en=1 -> RUN after the first tick; da_data steps 0x10..0x17, one per 4 clk, each change while clk_dac is low.
REQ-035 Push 16 samples with en=0 -> s_ready=0 and level=16; a 17th s_valid is not accepted; level stays 16.
REQ-036 Run the FIFO dry -> da_data holds 0x17, underflow=1, state PRIME; push 8 more -> playback resumes; clr_uf=1 -> underflow=0.
REQ-037 DAC_SIGNED_IN_EN defined, push 0x80, 0x00, 0x7F -> da_data 0x00, 0x80, 0xFF.
REQ-038 Assert rst mid-RUN with level=5 -> same-cycle da_data=0, clk_dac=0, level=0, s_ready=1.
REQ-039 DIV=2, DEPTH=4, push every clk with en=1 -> no underflow; clk_dac toggles every clk; no FIFO overflow.

Source files
------------

// File: rtl/dac_stream_ctrl.sv
// dac_stream_ctrl: sample FIFO feeding a DAC at a fixed divided sample rate.
// The FIFO is primed to half full before playback starts and re-primed after an underflow.
// Build option: define DAC_SIGNED_IN_EN to accept two's-complement samples.
// The sample MSB is then inverted at the FIFO output, giving offset-binary DAC codes.
module dac_stream_ctrl #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DIV   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [DW-1:0]            s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     clr_uf,
  output logic [DW-1:0]            da_data,
  output logic                     clk_dac,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [DW-1:0]   da_data_q, da_data_d;
  logic            clk_dac_q, clk_dac_d;
  logic            underflow_q, underflow_d;

  logic [DW-1:0]   mem_q [DEPTH];
  logic [DW-1:0]   fifo_out;
  logic            push;
  logic            pop;
  logic            tick;
  logic            uf_set;

  // Backpressure only when completely full.
  assign s_ready   = (level_q != LW'(DEPTH));
  assign da_data   = da_data_q;
  assign clk_dac   = clk_dac_q;
  assign level     = level_q;
  assign underflow = underflow_q;

  // Head-of-FIFO sample, converted to the DAC code format.
`ifdef DAC_SIGNED_IN_EN
  localparam logic [DW-1:0] MSB_MASK = DW'(1) << (DW - 1);
  assign fifo_out = mem_q[rd_ptr_q] ^ MSB_MASK;
`else
  assign fifo_out = mem_q[rd_ptr_q];
`endif

  // Sample storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  // Next-state, counter, FIFO bookkeeping and output register inputs.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    da_data_d   = da_data_q;
    clk_dac_d   = 1'b0;
    underflow_d = underflow_q;
    pop         = 1'b0;
    uf_set      = 1'b0;

    push = s_valid && s_ready;
    tick = en && (state_q != IDLE) && (count_q == CW'(DIV - 1));

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = PRIME;
        end
      end
      PRIME: begin
        if (tick && (level_q >= LW'(DEPTH / 2))) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (tick) begin
          if (level_q != '0) begin
            pop = 1'b1;
          end else begin
            uf_set  = 1'b1;
            state_d = PRIME;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!en) begin
      state_d = IDLE;
    end

    // Counter is parked at zero whenever playback is idle or disabled.
    if (!en || (state_q == IDLE)) begin
      count_d = '0;
    end else if (count_q == CW'(DIV - 1)) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(1);
    end

    // Registered from the next count so clk_dac lines up with count_q.
    clk_dac_d = (count_d >= CW'(DIV / 2));

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      da_data_d = fifo_out;
    end
    level_d = level_q + LW'(push) - LW'(pop);

    // A same-cycle set beats the clear.
    if (uf_set) begin
      underflow_d = 1'b1;
    end else if (clr_uf) begin
      underflow_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      da_data_q   <= '0;
      clk_dac_q   <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      da_data_q   <= da_data_d;
      clk_dac_q   <= clk_dac_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_dac_stream_ctrl.sv
// Directed bench for dac_stream_ctrl: default instance plus a DIV=2/DEPTH=4 instance.
module tb_dac_stream_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       clr_uf;
  logic [7:0] da_data;
  logic       clk_dac;
  logic [4:0] level;
  logic       underflow;

  logic       en2;
  logic [7:0] s_data2;
  logic       s_valid2;
  logic       s_ready2;
  logic [7:0] da_data2;
  logic       clk_dac2;
  logic [2:0] level2;
  logic       underflow2;

  int tests;
  int fails;

  dac_stream_ctrl #(.DW(8), .DEPTH(16), .DIV(4)) u_dut (
    .clk(clk), .rst(rst), .en(en), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .clr_uf(clr_uf), .da_data(da_data), .clk_dac(clk_dac),
    .level(level), .underflow(underflow)
  );

  dac_stream_ctrl #(.DW(8), .DEPTH(4), .DIV(2)) u_dut2 (
    .clk(clk), .rst(rst), .en(en2), .s_data(s_data2), .s_valid(s_valid2),
    .s_ready(s_ready2), .clr_uf(1'b0), .da_data(da_data2), .clk_dac(clk_dac2),
    .level(level2), .underflow(underflow2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected DAC code for an input sample.
  function automatic logic [7:0] code(input logic [7:0] s);
`ifdef DAC_SIGNED_IN_EN
    return s ^ 8'h80;
`else
    return s;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_one(input logic [7:0] d);
    s_valid = 1'b1;
    s_data  = d;
    tick(1);
    s_valid = 1'b0;
  endtask

  logic [7:0] d2;
  logic       acc;
  logic [7:0] tail [7];

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; en = 1'b0; s_data = '0; s_valid = 1'b0; clr_uf = 1'b0;
    en2 = 1'b0; s_data2 = '0; s_valid2 = 1'b0;
    tail[0] = 8'h80; tail[1] = 8'h00; tail[2] = 8'h7F; tail[3] = 8'h01;
    tail[4] = 8'h02; tail[5] = 8'h03; tail[6] = 8'h04;

    // Reset state
    tick(2);
    chk("rst_da", 32'(da_data), 32'h0);
    chk("rst_clk_dac", 32'(clk_dac), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_s_ready", 32'(s_ready), 32'h1);
    chk("rst_uf", 32'(underflow), 32'h0);
    chk("rst_s_ready2", 32'(s_ready2), 32'h1);
    rst = 1'b0;

    // Prime 8 samples, then play them back one per DIV clocks
    for (int i = 0; i < 8; i++) push_one(8'h10 + 8'(i));
    chk("prime_level", 32'(level), 32'd8);
    en = 1'b1;
    tick(5);
    chk("first_tick_no_pop_da", 32'(da_data), 32'h0);
    chk("first_tick_no_pop_lvl", 32'(level), 32'd8);
    tick(4);
    chk("pop0_da", 32'(da_data), 32'(code(8'h10)));
    chk("pop0_clk_dac", 32'(clk_dac), 32'h0);
    chk("pop0_lvl", 32'(level), 32'd7);
    for (int k = 1; k < 8; k++) begin
      tick(2);
      chk("hi_phase_clk_dac", 32'(clk_dac), 32'h1);
      chk("hi_phase_da_stable", 32'(da_data), 32'(code(8'h10 + 8'(k - 1))));
      tick(2);
      chk("step_da", 32'(da_data), 32'(code(8'h10 + 8'(k))));
      chk("step_clk_dac_low", 32'(clk_dac), 32'h0);
      chk("step_lvl", 32'(level), 32'(7 - k));
    end

    // Run dry: underflow, hold last sample, back to priming
    tick(4);
    chk("dry_uf", 32'(underflow), 32'h1);
    chk("dry_da_hold", 32'(da_data), 32'(code(8'h17)));
    chk("dry_lvl", 32'(level), 32'h0);
    for (int i = 0; i < 8; i++) push_one(8'h20 + 8'(i));
    chk("reprime_lvl", 32'(level), 32'd8);
    tick(4);
    chk("reprime_no_pop_lvl", 32'(level), 32'd8);
    chk("reprime_no_pop_da", 32'(da_data), 32'(code(8'h17)));
    tick(4);
    chk("resume_da", 32'(da_data), 32'(code(8'h20)));
    chk("resume_uf_sticky", 32'(underflow), 32'h1);
    clr_uf = 1'b1;
    tick(1);
    clr_uf = 1'b0;
    chk("clr_uf", 32'(underflow), 32'h0);
    tick(30);
    chk("drain2_lvl", 32'(level), 32'h0);
    chk("drain2_da", 32'(da_data), 32'(code(8'h27)));
    clr_uf = 1'b1;
    tick(1);
    chk("set_wins_over_clr", 32'(underflow), 32'h1);
    tick(1);
    chk("clr_after_set", 32'(underflow), 32'h0);
    clr_uf = 1'b0;

    // Disable, fill to full, reject overflow, retain da_data
    en = 1'b0;
    tick(1);
    for (int i = 0; i < 16; i++) push_one(8'h30 + 8'(i));
    chk("full_lvl", 32'(level), 32'd16);
    chk("full_s_ready", 32'(s_ready), 32'h0);
    push_one(8'h99);
    chk("overflow_rejected_lvl", 32'(level), 32'd16);
    chk("idle_da_retained", 32'(da_data), 32'(code(8'h27)));
    chk("idle_clk_dac", 32'(clk_dac), 32'h0);

    // Play from full, then reset asynchronously with level 5
    en = 1'b1;
    tick(5);
    chk("full_first_tick_lvl", 32'(level), 32'd16);
    tick(4);
    chk("full_pop0_da", 32'(da_data), 32'(code(8'h30)));
    tick(40);
    chk("pre_rst_da", 32'(da_data), 32'(code(8'h3A)));
    chk("pre_rst_lvl", 32'(level), 32'd5);
    tick(2);
    chk("pre_rst_clk_dac", 32'(clk_dac), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_da", 32'(da_data), 32'h0);
    chk("async_rst_clk_dac", 32'(clk_dac), 32'h0);
    chk("async_rst_lvl", 32'(level), 32'h0);
    chk("async_rst_s_ready", 32'(s_ready), 32'h1);
    en = 1'b0;
    tick(1);
    rst = 1'b0;

    // Push into an empty FIFO on a RUN tick: underflow, sample kept
    for (int i = 0; i < 8; i++) push_one(8'h40 + 8'(i));
    en = 1'b1;
    tick(40);
    chk("pre_collide_uf", 32'(underflow), 32'h0);
    chk("pre_collide_lvl", 32'(level), 32'h0);
    push_one(8'h55);
    chk("collide_uf", 32'(underflow), 32'h1);
    chk("collide_lvl", 32'(level), 32'h1);
    chk("collide_da_hold", 32'(da_data), 32'(code(8'h47)));
    for (int i = 0; i < 7; i++) push_one(tail[i]);
    chk("collide_refill_lvl", 32'(level), 32'd8);
    tick(5);
    chk("collide_sample_kept", 32'(da_data), 32'(code(8'h55)));
    chk("collide_pop_lvl", 32'(level), 32'd7);
    for (int i = 0; i < 3; i++) begin
      tick(4);
      chk("code_conv", 32'(da_data), 32'(code(tail[i])));
    end
    en = 1'b0;

    // DIV=2, DEPTH=4: stream continuously with s_valid held high
    d2 = 8'hA0;
    en2 = 1'b1;
    s_valid2 = 1'b1;
    s_data2 = d2;
    for (int k = 1; k <= 40; k++) begin
      acc = s_ready2;
      tick(1);
      if (acc) d2 = d2 + 8'd1;
      s_data2 = d2;
      chk("div2_clk_dac", 32'(clk_dac2), 32'((k % 2) == 0));
      chk("div2_no_uf", 32'(underflow2), 32'h0);
      chk("div2_lvl_bound", 32'(level2 <= 3'd4), 32'h1);
      if (k >= 5 && (k % 2) == 1)
        chk("div2_da", 32'(da_data2), 32'(code(8'hA0 + 8'((k - 5) / 2))));
    end
    s_valid2 = 1'b0;
    en2 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
